// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding select generator and load-use stall detector.
// Optional FWD_HAZARD_STATS_EN build adds saturating forward/stall event counters.
module fwd_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int NREGS_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush_ex,
    output logic              stall_id,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]       stat_fwd_cnt,
    output logic [15:0]       stat_stall_cnt
`endif
);

    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(NREGS_ZERO);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic              ex_valid_q,  ex_valid_d;
    logic [REG_AW-1:0] ex_rd_q,     ex_rd_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q,  ex_mem_read_d;

    logic              mem_valid_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_reg_write_q;

    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              wb_reg_write_q;

    logic [1:0]        fwd_a_d, fwd_b_d;
    logic              ex_writing, mem_writing, ex_bubble;

    // WB is kept for pipeline bookkeeping; its result has already reached the register file.
    logic              wb_unused;
    assign wb_unused = ^{wb_valid_q, wb_rd_q, wb_reg_write_q};

    assign ex_writing  = ex_valid_q  & ex_reg_write_q  & (ex_rd_q  != ZERO_REG);
    assign mem_writing = mem_valid_q & mem_reg_write_q & (mem_rd_q != ZERO_REG);

    assign stall_id = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != ZERO_REG) &
                      ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                       (id_use_rs2 & (id_rs2 == ex_rd_q)));

    assign ex_bubble = stall_id | flush_ex | ~id_valid;

    // The instruction now in EX will sit in MEM when the consumer reaches EX, so it takes priority.
    function automatic logic [1:0] next_sel(input logic use_rs, input logic [REG_AW-1:0] rs);
        if (use_rs && ex_writing && (ex_rd_q == rs)) begin
            return SEL_MEM;
        end else if (use_rs && mem_writing && (mem_rd_q == rs)) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_rd_d        = '0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        fwd_a_d        = SEL_RF;
        fwd_b_d        = SEL_RF;
        if (!ex_bubble) begin
            ex_valid_d     = 1'b1;
            ex_rd_d        = id_rd;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
            fwd_a_d        = next_sel(id_use_rs1, id_rs1);
            fwd_b_d        = next_sel(id_use_rs2, id_rs2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            fwd_a           <= SEL_RF;
            fwd_b           <= SEL_RF;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            wb_valid_q      <= mem_valid_q;
            wb_rd_q         <= mem_rd_q;
            wb_reg_write_q  <= mem_reg_write_q;
            fwd_a           <= fwd_a_d;
            fwd_b           <= fwd_b_d;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic fwd_active;
    assign fwd_active = (fwd_a != SEL_RF) | (fwd_b != SEL_RF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (fwd_active && (stat_fwd_cnt != 16'hFFFF)) begin
                stat_fwd_cnt <= stat_fwd_cnt + 16'd1;
            end
            if (stall_id && (stat_stall_cnt != 16'hFFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit; expected selects are hand-derived per instruction sequence.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_use_rs1 = 1'b0;
    logic       id_use_rs2 = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       flush_ex = 1'b0;
    logic       stall_id;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stat_fwd_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(5), .NREGS_ZERO(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush_ex     (flush_ex),
        .stall_id     (stall_id),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stat_fwd_cnt   (stat_fwd_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush_ex = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        chk("reset_fwd_a", 16'(fwd_a), 16'd0);
        chk("reset_fwd_b", 16'(fwd_b), 16'd0);
        chk("reset_stall", 16'(stall_id), 16'd0);

        // back-to-back ALU dependency
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        step();
        chk("b2b_first_fwd_a", 16'(fwd_a), 16'd0);
        drive(1, 5'd5, 5'd6, 1, 1, 5'd8, 1, 0);
        chk("b2b_stall", 16'(stall_id), 16'd0);
        step();
        chk("b2b_fwd_a", 16'(fwd_a), 16'b10);
        chk("b2b_fwd_b", 16'(fwd_b), 16'b00);

        // two-apart dependency
        drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);
        step();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0);
        step();
        drive(1, 5'd1, 5'd7, 1, 1, 5'd10, 1, 0);
        step();
        chk("gap1_fwd_b", 16'(fwd_b), 16'b01);
        chk("gap1_fwd_a", 16'(fwd_a), 16'b00);

        // both intervening instructions write x7: youngest wins
        drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);
        step();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0);
        step();
        drive(1, 5'd1, 5'd7, 1, 1, 5'd10, 1, 0);
        step();
        chk("dual_fwd_b", 16'(fwd_b), 16'b10);

        // load-use
        drive(1, 5'd2, 5'd0, 1, 0, 5'd3, 1, 1);
        chk("ld_no_stall", 16'(stall_id), 16'd0);
        step();
        drive(1, 5'd3, 5'd4, 1, 1, 5'd10, 1, 0);
        chk("lu_stall", 16'(stall_id), 16'd1);
        step();
        chk("lu_bubble_fwd_a", 16'(fwd_a), 16'd0);
        chk("lu_bubble_fwd_b", 16'(fwd_b), 16'd0);
        chk("lu_stall_released", 16'(stall_id), 16'd0);
        step();
        chk("lu_held_fwd_a", 16'(fwd_a), 16'b01);
        chk("lu_held_fwd_b", 16'(fwd_b), 16'b00);

        // x0 never forwards or stalls
        drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 1);
        step();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd11, 1, 0);
        chk("x0_stall", 16'(stall_id), 16'd0);
        step();
        chk("x0_fwd_a", 16'(fwd_a), 16'd0);
        chk("x0_fwd_b", 16'(fwd_b), 16'd0);

        // unused rs2 matching a load
        drive(1, 5'd1, 5'd2, 1, 1, 5'd12, 1, 1);
        step();
        drive(1, 5'd1, 5'd12, 1, 0, 5'd14, 1, 0);
        chk("unused_rs2_stall", 16'(stall_id), 16'd0);
        step();
        chk("unused_rs2_fwd_b", 16'(fwd_b), 16'd0);
        chk("unused_rs2_fwd_a", 16'(fwd_a), 16'd0);

        // flushed producer must not forward
        drive(1, 5'd1, 5'd2, 1, 1, 5'd13, 1, 0);
        flush_ex = 1'b1;
        step();
        flush_ex = 1'b0;
        chk("flush_bubble_fwd_a", 16'(fwd_a), 16'd0);
        drive(1, 5'd13, 5'd13, 1, 1, 5'd16, 1, 0);
        step();
        chk("flush_next_fwd_a", 16'(fwd_a), 16'd0);
        chk("flush_next_fwd_b", 16'(fwd_b), 16'd0);
        drive(1, 5'd13, 5'd1, 1, 1, 5'd17, 1, 0);
        step();
        chk("flush_next2_fwd_a", 16'(fwd_a), 16'd0);

        // flush together with load-use stall
        drive(1, 5'd1, 5'd2, 1, 1, 5'd15, 1, 1);
        step();
        drive(1, 5'd15, 5'd1, 1, 1, 5'd18, 1, 0);
        flush_ex = 1'b1;
        #1;
        chk("flush_stall_asserted", 16'(stall_id), 16'd1);
        step();
        flush_ex = 1'b0;
        #1;
        chk("flush_stall_fwd_a", 16'(fwd_a), 16'd0);
        chk("flush_stall_released", 16'(stall_id), 16'd0);
        step();
        chk("flush_stall_held_fwd_a", 16'(fwd_a), 16'b01);

        // asynchronous reset mid-stream
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        step();
        drive(1, 5'd5, 5'd2, 1, 1, 5'd20, 1, 0);
        step();
        chk("pre_rst_fwd_a", 16'(fwd_a), 16'b10);
        drive(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 1);
        step();
        chk("pre_rst_load_fwd_a", 16'(fwd_a), 16'b01);
        drive(1, 5'd6, 5'd2, 1, 1, 5'd21, 1, 0);
        chk("pre_rst_stall", 16'(stall_id), 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_fwd_a", 16'(fwd_a), 16'd0);
        chk("async_rst_fwd_b", 16'(fwd_b), 16'd0);
        chk("async_rst_stall", 16'(stall_id), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_stall", 16'(stall_id), 16'd0);
        step();
        chk("post_rst_fwd_a", 16'(fwd_a), 16'd0);

`ifdef FWD_HAZARD_STATS_EN
        do_reset();
        chk("stat_rst_fwd", stat_fwd_cnt, 16'd0);
        chk("stat_rst_stall", stat_stall_cnt, 16'd0);
        drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        step();
        drive(1, 5'd5, 5'd2, 1, 1, 5'd21, 1, 0);
        step();
        drive(1, 5'd21, 5'd5, 1, 1, 5'd22, 1, 0);
        step();
        chk("stat_c_fwd_a", 16'(fwd_a), 16'b10);
        chk("stat_c_fwd_b", 16'(fwd_b), 16'b01);
        drive(1, 5'd1, 5'd2, 1, 1, 5'd23, 1, 1);
        step();
        drive(1, 5'd23, 5'd2, 1, 1, 5'd24, 1, 0);
        step();
        step();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd25, 1, 1);
        step();
        drive(1, 5'd1, 5'd25, 1, 1, 5'd26, 1, 0);
        step();
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        step();
        step();
        chk("stat_fwd_cnt", stat_fwd_cnt, 16'd3);
        chk("stat_stall_cnt", stat_stall_cnt, 16'd2);

        do_reset();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        chk("stat_fwd_sat", stat_fwd_cnt, 16'hFFFF);
        step();
        chk("stat_fwd_sat_hold", stat_fwd_cnt, 16'hFFFF);
        chk("stat_stall_idle", stat_stall_cnt, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Producer of the 2-bit select codes consumed by the pipeline's three-input forwarding muxes on the EX-stage ALU operands A and B.
- Tracks destination-register info for instructions in EX, MEM and WB in internal pipeline registers.
- Emits registered forwarding selects aligned to the EX stage.
- Raises a combinational load-use stall toward fetch/decode.

Parameters:
- REG_AW, 5, register-address width
- NREGS_ZERO, 0, index of the hardwired-zero register; never a forwarding source

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode-stage instruction is valid
- id_rs1  input  REG_AW  decode-stage source register 1
- id_rs2  input  REG_AW  decode-stage source register 2
- id_use_rs1  input  1  instruction reads rs1
- id_use_rs2  input  1  instruction reads rs2
- id_rd  input  REG_AW  decode-stage destination register
- id_reg_write  input  1  instruction writes rd
- id_mem_read  input  1  instruction is a load
- flush_ex  input  1  branch/jump taken; instruction entering EX is killed
- stall_id  output  1  load-use hazard; hold PC and IF/ID, bubble EX
- fwd_a  output  2  operand A select, valid during EX
- fwd_b  output  2  operand B select, valid during EX

Behaviour:
- Select encoding: 00 = register-file value; 01 = WB result; 10 = MEM ALU result. 11 is never driven.
- Internal stage records: EX{valid, rd, reg_write, mem_read}, MEM{valid, rd, reg_write}, WB{valid, rd, reg_write}. All advance every clock. There is no back-pressure beyond stall_id.
- Record validity: a record is "writing" only if valid & reg_write & rd != NREGS_ZERO.
- stall_id (combinational) = id_valid & EX.valid & EX.mem_read & EX.rd != NREGS_ZERO & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
- EX load rule: EX loads a bubble (all fields 0) if stall_id | flush_ex | !id_valid. Otherwise EX loads the id_* fields.
- Shift rule: MEM <= EX and WB <= MEM unconditionally.
- Next-select for operand A, computed in ID:
  - if id_use_rs1 & EX writing & EX.rd == id_rs1 -> 10 (EX becomes MEM next cycle);
  - else if id_use_rs1 & MEM writing & MEM.rd == id_rs1 -> 01;
  - else 00.
  - The youngest producer wins.
  - Operand B uses the same rule with rs2.
- Select registering: fwd_a/fwd_b register next-select on the same edge EX loads, giving one-cycle latency aligned with the EX stage.
  - When EX loads a bubble, both selects register 00.
- Reset: rst_n low asynchronously clears all stage records, fwd_a = fwd_b = 00, stall_id = 0 (derived from the cleared EX record). Reset mid-stream discards all in-flight records. The first post-reset edge behaves as from empty.
- Simultaneous events:
  - flush_ex with stall_id -> bubble into EX; stall_id still asserted that cycle.
  - An rd match in both EX and MEM -> 10.
  - rd == NREGS_ZERO never forwards or stalls.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, adds outputs:
  - stat_fwd_cnt (16-bit): increments once per registered cycle where fwd_a != 00 or fwd_b != 00.
  - stat_stall_cnt (16-bit): increments per cycle stall_id = 1.
  - Both counters saturate at 16'hFFFF and clear on rst_n.
- When undefined, these ports and the counter logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: add x5 (reg_write), then next cycle sub reading rs1 = x5.
  - Response: after the edge capturing sub, fwd_a = 10, fwd_b = 00, stall_id = 0.
- Two-apart dependency:
  - Stimulus: write x7, one unrelated instruction, then read rs2 = x7.
  - Response: fwd_b = 01.
  - Variant: both intervening instructions write x7 -> fwd_b = 10.
- Load-use:
  - Stimulus: load rd = x3, next instruction uses rs1 = x3.
  - Response: stall_id = 1 for exactly one cycle; EX gets a bubble (fwd 00); the held instruction then registers fwd_a = 01.
- x0 and unused operands:
  - Stimulus: write to x0 then read x0; also a match on rs2 with id_use_rs2 = 0.
  - Response: fwd = 00 and stall_id = 0 in all cases.
- Flush and reset:
  - Stimulus: flush_ex asserted with a matching producer in flight.
  - Response: EX bubble; a subsequent consumer sees no forward from the killed instruction.
  - Stimulus: rst_n pulsed low mid-sequence.
  - Response: fwd_a = fwd_b = 00 and stall_id = 0 immediately, without waiting for clk.
- FWD_HAZARD_STATS_EN build:
  - Stimulus: 3 forwarding cycles and 2 stall cycles.
  - Response: stat_fwd_cnt = 3, stat_stall_cnt = 2.
  - Stimulus: preload to saturation.
  - Response: counters hold at 16'hFFFF.
